uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Byte FIFO and launch controller sitting directly upstream of the UART transmitter. The CPU side writes bytes at up to one per clock. The block stores them and hands them one at a time to the transmitter through its `data`/`send`/`sending` handshake. It absorbs bursts so the CPU never has to poll `sending` itself.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_data` input 8: byte to enqueue.
- `wr_en` input 1: enqueue request, sampled each edge.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `count` output `ADDR_W+1`: bytes stored, 0..`DEPTH`.
- `overflow` output 1: sticky. Set when a write is dropped.
- `ovf_clr` input 1: clears `overflow`.
- `tx_data` output 8: byte presented to the transmitter's `data` input.
- `tx_send` output 1: one-cycle launch strobe to the transmitter's `send` input.
- `tx_sending` input 1: the transmitter's `sending` output.

## Operation
- Reset values: `count` 0, `empty` 1, `full` 0, `overflow` 0, `tx_data` 8'h00, `tx_send` 0. Read and write pointers are 0. FSM is in IDLE.
- Write path:
  - `wr_en && !full` at an edge stores `wr_data` at `wr_ptr`; `wr_ptr` advances modulo `DEPTH`.
  - `wr_en && full` drops the byte and sets `overflow`.
  - `full` is evaluated on the pre-edge `count`. A write in the same cycle as a pop while full is still dropped.
- `ovf_clr` clears `overflow`. If `ovf_clr` and a dropped write occur at the same edge, the set wins.
- `count` gains 1 on an accepted write and loses 1 on a pop. Both at the same edge leave `count` unchanged.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - **IDLE**: if `!empty && !tx_sending`, at the edge: `tx_data <= mem[rd_ptr]`, `tx_send <= 1`, `rd_ptr` advances (pop), go to WAIT_BUSY. Otherwise stay.
  - **WAIT_BUSY**: `tx_send <= 0`. If `tx_sending`, go to WAIT_DONE.
  - **WAIT_DONE**: if `!tx_sending`, go to IDLE.
- `tx_send` is never high for more than one cycle. `tx_data` holds its value until the next launch.
- A byte written while the FIFO is empty is not launched at the same edge. The IDLE decision uses the pre-edge `empty`.
- Reset mid-frame:
  - The buffer clears immediately; queued bytes are lost.
  - The transmitter is not reset by this block and may finish its frame.
  - IDLE's `!tx_sending` guard prevents a launch until that frame ends.

## Timing
- The transmitter accepts `send` at the edge where it samples `send` high while idle (edge E2 below). Its `sending` is high from that edge until 11 edges later.
- First byte into an empty FIFO:
  - Write accepted at E0.
  - IDLE launch at E1; `tx_send` is high between E1 and E2.
  - Transmitter latches at E2.
  - WAIT_BUSY sees `sending` at E3.
  - `sending` falls at E13.
  - WAIT_DONE exits at E14.
  - Next launch at E15.
- Back-to-back bytes: exactly 14 clocks per byte, from one `tx_send` pulse to the next.
- Write-to-`full`/`empty`/`count` update: one edge. No combinational path from `wr_en` to any output.

## Structure
- Shared package `uart_pkg`: state encoding (`IDLE`, `WAIT_BUSY`, `WAIT_DONE`) and `UART_DATA_W = 8`. The transmitter and the future receiver use the same package.
- Sub-module `sync_fifo`: holds storage, pointers, `count`, `full`, `empty` and `overflow`, parameterised by `DEPTH`/`ADDR_W`. `uart_tx_buffer` holds the FSM and the `tx_*` registers.

## Test plan
- Reset, then write 8'hA5 once; model the transmitter with the `sending` behaviour above -> `tx_send` pulses once, one edge after the write, with `tx_data` = 8'hA5; `empty` = 1 after the pop.
- Burst-write 8'h01..8'h04 on consecutive clocks -> `count` peaks at 3 (the first byte pops on the edge after its write); `tx_send` pulses 14 clocks apart with data 01, 02, 03, 04 in order.
- Hold `tx_sending` = 1 and write 17 bytes into `DEPTH` = 16 -> `full` = 1, `count` = 16, `overflow` = 1, the 17th byte is absent; pulse `ovf_clr` -> `overflow` = 0.
- Pointer wrap: push and drain 40 bytes with an incrementing pattern -> output order matches exactly across two pointer wraps.
- Assert `rst_n` low while WAIT_DONE with 5 bytes queued and `tx_sending` = 1 -> all outputs return to reset values at once; no `tx_send` until `tx_sending` falls.
- While full with a pop in progress, write in the same cycle -> byte dropped, `overflow` = 1, `count` = 15 after the edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit buffer, the transmitter and the receiver.
//   UART_DATA_W : width of one UART data byte
//   tx_state_e  : launch controller state encoding
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Signal bundle between the CPU/transmitter side and uart_tx_buffer.
//   wr_data, wr_en, ovf_clr        : CPU write side into the buffer
//   full, empty, count, overflow   : buffer status back to the CPU
//   tx_data, tx_send               : launch toward the transmitter
//   tx_sending                     : transmitter busy flag
// slave modport is the buffer's view; master is the surrounding system's view.
interface uart_tx_buffer_if
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
);
    logic [UART_DATA_W-1:0] wr_data;
    logic                   wr_en;
    logic                   full;
    logic                   empty;
    logic [ADDR_W:0]        count;
    logic                   overflow;
    logic                   ovf_clr;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_send;
    logic                   tx_sending;

    modport slave (
        input  wr_data, wr_en, ovf_clr, tx_sending,
        output full, empty, count, overflow, tx_data, tx_send
    );

    modport master (
        output wr_data, wr_en, ovf_clr, tx_sending,
        input  full, empty, count, overflow, tx_data, tx_send
    );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with occupancy count and sticky overflow flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en_i      : enqueue wr_data_i unless full (dropped write sets overflow_o)
//   rd_en_i      : pop the head entry; ignored when empty
//   ovf_clr_i    : clear overflow_o (a simultaneous dropped write wins)
//   rd_data_o    : head entry, valid when !empty_o
//   count_o, full_o, empty_o, overflow_o : status, all registered
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic                   ovf_clr_i,
    output logic [UART_DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]        count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   full, empty;
    logic                   wr_accept, pop;

    // Both flags come from the pre-edge count, so a pop never frees room for a same-edge write.
    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);

    always_comb begin
        wr_accept  = wr_en_i && !full;
        pop        = rd_en_i && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        // Power-of-two depth: pointer wrap is plain overflow of the ADDR_W-bit add.
        if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en_i && full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer and launch controller in front of the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   buf_if     : slave side of uart_tx_buffer_if (CPU writes/status, transmitter handshake)
// Bytes are queued in sync_fifo and launched one at a time: a one-cycle tx_send pulse, then
// wait for the transmitter to raise and drop tx_sending before the next launch.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_buffer_if.slave   buf_if
);

    tx_state_e              state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;
    logic                   pop;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic                   launch;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (buf_if.wr_en),
        .wr_data_i  (buf_if.wr_data),
        .rd_en_i    (pop),
        .ovf_clr_i  (buf_if.ovf_clr),
        .rd_data_o  (fifo_rd_data),
        .count_o    (buf_if.count),
        .full_o     (buf_if.full),
        .empty_o    (fifo_empty),
        .overflow_o (buf_if.overflow)
    );

    // The tx_sending guard also blocks a launch while a frame started before reset is finishing.
    assign launch = (state_q == IDLE) && !fifo_empty && !buf_if.tx_sending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (launch)             state_d = WAIT_BUSY;
            WAIT_BUSY: if (buf_if.tx_sending)  state_d = WAIT_DONE;
            WAIT_DONE: if (!buf_if.tx_sending) state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        if (launch) begin
            pop       = 1'b1;
            tx_send_d = 1'b1;
            tx_data_d = fifo_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
        end
    end

    assign buf_if.empty   = fifo_empty;
    assign buf_if.tx_data = tx_data_q;
    assign buf_if.tx_send = tx_send_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with a behavioural transmitter model:
// sending rises at the edge that samples tx_send high while idle and falls 11 edges later.
module tb_uart_tx_buffer;

    logic clk = 1'b0;
    logic rst_n;
    logic force_busy = 1'b0;
    logic model_sending = 1'b0;
    int   model_cnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] pulse_data [$];
    int         pulse_cyc  [$];

    uart_tx_buffer_if #(.ADDR_W(4)) bus_if ();

    uart_tx_buffer #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .buf_if (bus_if)
    );

    always #5 clk = ~clk;

    assign bus_if.tx_sending = force_busy | model_sending;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model; not reset by rst_n.
    always @(posedge clk) begin
        if (model_sending) begin
            if (model_cnt == 10) model_sending <= 1'b0;
            else                 model_cnt <= model_cnt + 1;
        end else if (bus_if.tx_send) begin
            model_sending <= 1'b1;
            model_cnt     <= 0;
        end
    end

    always @(negedge clk) begin
        if (bus_if.tx_send) begin
            pulse_data.push_back(bus_if.tx_data);
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        pulse_data.delete();
        pulse_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.wr_en = 1'b0;
        bus_if.wr_data = 8'h00;
        bus_if.ovf_clr = 1'b0;
        tick();
        tick();
        checks += 6;
        if (bus_if.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", bus_if.count); end
        if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, expected 1", bus_if.empty); end
        if (bus_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, expected 0", bus_if.full); end
        if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", bus_if.overflow); end
        if (bus_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, expected 00", bus_if.tx_data); end
        if (bus_if.tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b, expected 0", bus_if.tx_send); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        clear_log();
        bus_if.wr_data = 8'hA5;
        bus_if.wr_en = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        checks += 3;
        if (bus_if.count !== 5'd1) begin errors++; $display("FAIL single_count_after_write: got %0d, expected 1", bus_if.count); end
        if (bus_if.empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write: got %b, expected 0", bus_if.empty); end
        if (bus_if.tx_send !== 1'b0) begin errors++; $display("FAIL single_no_same_edge_launch: got %b, expected 0", bus_if.tx_send); end
        tick();
        checks += 4;
        if (bus_if.tx_send !== 1'b1) begin errors++; $display("FAIL single_launch: got %b, expected 1", bus_if.tx_send); end
        if (bus_if.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h, expected a5", bus_if.tx_data); end
        if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b, expected 1", bus_if.empty); end
        if (bus_if.count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d, expected 0", bus_if.count); end
        tick();
        checks += 2;
        if (bus_if.tx_send !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b, expected 0", bus_if.tx_send); end
        if (bus_if.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data_hold: got %h, expected a5", bus_if.tx_data); end
        repeat (20) tick();
        checks++;
        if (pulse_data.size() != 1) begin errors++; $display("FAIL single_pulse_count: got %0d, expected 1", pulse_data.size()); end
    endtask

    task automatic test_burst();
        int peak = 0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            bus_if.wr_data = 8'(i + 1);
            bus_if.wr_en = 1'b1;
            tick();
            if (int'(bus_if.count) > peak) peak = int'(bus_if.count);
        end
        bus_if.wr_en = 1'b0;
        repeat (70) begin
            tick();
            if (int'(bus_if.count) > peak) peak = int'(bus_if.count);
        end
        checks += 2;
        if (peak != 3) begin errors++; $display("FAIL burst_peak_count: got %0d, expected 3", peak); end
        if (pulse_data.size() != 4) begin errors++; $display("FAIL burst_pulse_count: got %0d, expected 4", pulse_data.size()); end
        for (int i = 0; i < pulse_data.size() && i < 4; i++) begin
            checks++;
            if (pulse_data[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL burst_data[%0d]: got %h, expected %h", i, pulse_data[i], 8'(i + 1));
            end
        end
        for (int i = 0; i + 1 < pulse_cyc.size(); i++) begin
            checks++;
            if (pulse_cyc[i + 1] - pulse_cyc[i] != 14) begin
                errors++; $display("FAIL burst_spacing[%0d]: got %0d clocks, expected 14", i, pulse_cyc[i + 1] - pulse_cyc[i]);
            end
        end
    endtask

    task automatic test_full();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            bus_if.wr_data = 8'(8'h10 + i);
            bus_if.wr_en = 1'b1;
            tick();
        end
        bus_if.wr_en = 1'b0;
        checks += 5;
        if (bus_if.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b, expected 1", bus_if.full); end
        if (bus_if.count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d, expected 16", bus_if.count); end
        if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b, expected 1", bus_if.overflow); end
        if (bus_if.empty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b, expected 0", bus_if.empty); end
        if (bus_if.tx_send !== 1'b0) begin errors++; $display("FAIL full_no_launch_busy: got %b, expected 0", bus_if.tx_send); end
        bus_if.ovf_clr = 1'b1;
        tick();
        bus_if.ovf_clr = 1'b0;
        checks += 2;
        if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b, expected 0", bus_if.overflow); end
        if (bus_if.count !== 5'd16) begin errors++; $display("FAIL ovf_clr_count: got %0d, expected 16", bus_if.count); end
        // Clear and dropped write on the same edge: the set wins.
        bus_if.ovf_clr = 1'b1;
        bus_if.wr_data = 8'hDD;
        bus_if.wr_en = 1'b1;
        tick();
        bus_if.ovf_clr = 1'b0;
        bus_if.wr_en = 1'b0;
        checks++;
        if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b, expected 1", bus_if.overflow); end
        bus_if.ovf_clr = 1'b1;
        tick();
        bus_if.ovf_clr = 1'b0;
    endtask

    task automatic test_full_pop();
        clear_log();
        force_busy = 1'b0;
        bus_if.wr_data = 8'hEE;
        bus_if.wr_en = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        checks += 4;
        if (bus_if.tx_send !== 1'b1) begin errors++; $display("FAIL fullpop_launch: got %b, expected 1", bus_if.tx_send); end
        if (bus_if.count !== 5'd15) begin errors++; $display("FAIL fullpop_count: got %0d, expected 15", bus_if.count); end
        if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow: got %b, expected 1", bus_if.overflow); end
        if (bus_if.full !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b, expected 0", bus_if.full); end
        repeat (16 * 14 + 10) tick();
        checks += 2;
        if (pulse_data.size() != 16) begin errors++; $display("FAIL fullpop_pulse_count: got %0d, expected 16", pulse_data.size()); end
        if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL fullpop_drained: got %b, expected 1", bus_if.empty); end
        for (int i = 0; i < pulse_data.size() && i < 16; i++) begin
            checks++;
            if (pulse_data[i] !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL fullpop_data[%0d]: got %h, expected %h", i, pulse_data[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        bus_if.ovf_clr = 1'b1;
        tick();
        bus_if.ovf_clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int w = 0;
            while (bus_if.full && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) begin
                checks++; errors++; $display("FAIL wrap_full_timeout: got full=1 after 200 clocks, expected space");
            end
            bus_if.wr_data = 8'(8'h40 + i);
            bus_if.wr_en = 1'b1;
            tick();
            bus_if.wr_en = 1'b0;
        end
        repeat (16 * 14 + 40) tick();
        checks += 3;
        if (pulse_data.size() != 40) begin errors++; $display("FAIL wrap_pulse_count: got %0d, expected 40", pulse_data.size()); end
        if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b, expected 0", bus_if.overflow); end
        if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL wrap_drained: got %b, expected 1", bus_if.empty); end
        for (int i = 0; i < pulse_data.size() && i < 40; i++) begin
            checks++;
            if (pulse_data[i] !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL wrap_data[%0d]: got %h, expected %h", i, pulse_data[i], 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int  w = 0;
        bit  early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_if.wr_data = 8'(8'h60 + i);
            bus_if.wr_en = 1'b1;
            tick();
        end
        bus_if.wr_en = 1'b0;
        checks++;
        if (bus_if.count !== 5'd5) begin errors++; $display("FAIL midrst_queued: got %0d, expected 5", bus_if.count); end
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (bus_if.count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d, expected 0", bus_if.count); end
        if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b, expected 1", bus_if.empty); end
        if (bus_if.full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b, expected 0", bus_if.full); end
        if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b, expected 0", bus_if.overflow); end
        if (bus_if.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h, expected 00", bus_if.tx_data); end
        if (bus_if.tx_send !== 1'b0) begin errors++; $display("FAIL midrst_tx_send: got %b, expected 0", bus_if.tx_send); end
        tick();
        rst_n = 1'b1;
        clear_log();
        bus_if.wr_data = 8'h77;
        bus_if.wr_en = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        checks++;
        if (bus_if.count !== 5'd1) begin errors++; $display("FAIL midrst_write_after: got %0d, expected 1", bus_if.count); end
        while (bus_if.tx_sending && w < 30) begin
            if (bus_if.tx_send) early = 1'b1;
            tick();
            w++;
        end
        checks += 2;
        if (w >= 30) begin errors++; $display("FAIL midrst_sending_timeout: got sending=1 after 30 clocks, expected 0"); end
        if (early) begin errors++; $display("FAIL midrst_early_launch: got tx_send while sending, expected none"); end
        repeat (20) tick();
        checks++;
        if (pulse_data.size() != 1) begin
            errors++; $display("FAIL midrst_pulse_count: got %0d, expected 1", pulse_data.size());
        end else begin
            checks++;
            if (pulse_data[0] !== 8'h77) begin errors++; $display("FAIL midrst_data: got %h, expected 77", pulse_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
